reg_file_2r1w: RTL and testbench

Architectural register file for the 16-bit pipelined core, read in the decode stage and written from writeback. It holds 16 general registers of 16 bits each. It provides two combinational read ports with same-cycle write-to-read bypass and one synchronous write port. R0 is hardwired to zero.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/rf_wr_decoder.sv | 18 +
 rtl/reg_file_2r1w.sv | 62 ++++++
 tb/tb_reg_file_2r1w.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit pipelined core.
package cpu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG   = 4'd0;
  // Reset polarity shared by every sequential block in the core.
  localparam logic              RST_ACTIVE = 1'b0;

endpackage

// File: rtl/rf_wr_decoder.sv
// One-hot row write-enable decoder for the register file; row 0 never enabled.
module rf_wr_decoder
  import cpu_pkg::*;
(
  input  logic                i_wrt_en,
  input  logic [ADDR_W-1:0]   i_dst_reg,
  output logic [NUM_REGS-1:0] o_row_we
);

  always_comb begin
    o_row_we = '0;
    if (i_wrt_en) begin
      o_row_we[i_dst_reg] = 1'b1;
    end
    o_row_we[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Architectural register file: 16x16, two combinational read ports with
// same-cycle write bypass, one synchronous write port, R0 hardwired to zero.
module reg_file_2r1w
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] src_reg1,
  input  logic [ADDR_W-1:0] src_reg2,
  input  logic [ADDR_W-1:0] dst_reg,
  input  logic              wrt_en,
  input  logic [DATA_W-1:0] dst_data,
  output logic [DATA_W-1:0] src_data1,
  output logic [DATA_W-1:0] src_data2
);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_row_we;
  logic                w_rst_off;
  logic                w_byp1;
  logic                w_byp2;

  rf_wr_decoder u_wr_dec (
    .i_wrt_en  (wrt_en),
    .i_dst_reg (dst_reg),
    .o_row_we  (w_row_we)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_row_we[i]) begin
          r_regs[i] <= dst_data;
        end
      end
    end
  end

  // Bypass is suppressed while reset is held so outputs stay at zero.
  assign w_rst_off = (rst != RST_ACTIVE);
  assign w_byp1    = wrt_en && (dst_reg == src_reg1);
  assign w_byp2    = wrt_en && (dst_reg == src_reg2);

  always_comb begin
    src_data1 = '0;
    if (w_rst_off && (src_reg1 != ZERO_REG)) begin
      src_data1 = w_byp1 ? dst_data : r_regs[src_reg1];
    end
  end

  always_comb begin
    src_data2 = '0;
    if (w_rst_off && (src_reg2 != ZERO_REG)) begin
      src_data2 = w_byp2 ? dst_data : r_regs[src_reg2];
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: behavioural model plus directed vectors.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  src_reg1 = '0;
  logic [3:0]  src_reg2 = '0;
  logic [3:0]  dst_reg  = '0;
  logic        wrt_en   = 1'b0;
  logic [15:0] dst_data = '0;
  logic [15:0] src_data1;
  logic [15:0] src_data2;

  int total = 0;
  int bad   = 0;

  reg_file_2r1w dut (
    .clk       (clk),
    .rst       (rst),
    .src_reg1  (src_reg1),
    .src_reg2  (src_reg2),
    .dst_reg   (dst_reg),
    .wrt_en    (wrt_en),
    .dst_data  (dst_data),
    .src_data1 (src_data1),
    .src_data2 (src_data2)
  );

  always #5 clk = ~clk;

  // Architectural model: plain array of register contents.
  logic [15:0] mdl [16];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mdl[i] <= 16'h0000;
    end else if (wrt_en && dst_reg != 4'd0) begin
      mdl[dst_reg] <= dst_data;
    end
  end

  // What a read of idx must return right now, before any pending edge.
  function automatic logic [15:0] exp_read(input logic [3:0] idx);
    if (!rst || idx == 4'd0) return 16'h0000;
    if (wrt_en && dst_reg == idx) return dst_data;
    return mdl[idx];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_p1", src_data1, exp_read(src_reg1));
    chk("model_p2", src_data2, exp_read(src_reg2));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic we, input logic [3:0] d, input logic [15:0] dat,
                       input logic [3:0] s1, input logic [3:0] s2);
    wrt_en   = we;
    dst_reg  = d;
    dst_data = dat;
    src_reg1 = s1;
    src_reg2 = s2;
    #1;
  endtask

  task automatic wr(input logic [3:0] d, input logic [15:0] dat);
    drive(1'b1, d, dat, 4'd0, 4'd0);
    step();
  endtask

  initial begin
    // Reset held for two cycles; a write attempt under reset must be ignored.
    step();
    drive(1'b1, 4'd5, 16'hA5A5, 4'd5, 4'd5);
    chk("rst_bypass_supp", src_data1, 16'h0000);
    step();
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd15);
    chk("t1_r5", src_data1, 16'h0000);
    chk("t1_r15", src_data2, 16'h0000);

    // Write then read.
    step();
    wr(4'd3, 16'hBEEF);
    drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd4);
    chk("t2_r3", src_data1, 16'hBEEF);
    chk("t2_r4", src_data2, 16'h0000);

    // Bypass on both ports, then storage after the edge.
    wr(4'd7, 16'h1111);
    drive(1'b1, 4'd7, 16'h2222, 4'd7, 4'd7);
    chk("t3_byp_p1", src_data1, 16'h2222);
    chk("t3_byp_p2", src_data2, 16'h2222);
    step();
    drive(1'b0, 4'd0, 16'h0000, 4'd7, 4'd7);
    chk("t3_post_p1", src_data1, 16'h2222);
    chk("t3_post_p2", src_data2, 16'h2222);

    // R0 protection.
    drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
    chk("t4_r0_pre", src_data1, 16'h0000);
    step();
    drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
    chk("t4_r0_post", src_data1, 16'h0000);
    chk("t4_r0_post_p2", src_data2, 16'h0000);

    // Port independence.
    wr(4'd1, 16'h00AA);
    wr(4'd2, 16'h0055);
    drive(1'b1, 4'd2, 16'h1234, 4'd1, 4'd2);
    chk("t5_p1", src_data1, 16'h00AA);
    chk("t5_p2", src_data2, 16'h1234);
    step();
    drive(1'b0, 4'd0, 16'h0000, 4'd2, 4'd1);
    chk("t5_post_p1", src_data1, 16'h1234);
    chk("t5_post_p2", src_data2, 16'h00AA);

    // Async reset mid-write.
    wr(4'd9, 16'hCAFE);
    drive(1'b1, 4'd9, 16'h0001, 4'd9, 4'd9);
    chk("t6_byp", src_data1, 16'h0001);
    rst = 1'b0;
    #1;
    chk("t6_async_p1", src_data1, 16'h0000);
    chk("t6_async_p2", src_data2, 16'h0000);
    step();
    rst = 1'b1;
    drive(1'b0, 4'd0, 16'h0000, 4'd9, 4'd3);
    chk("t6_after_r9", src_data1, 16'h0000);
    chk("t6_after_r3", src_data2, 16'h0000);

    // Sweep: fill every register, then read back pairs; model checks each cycle.
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 16'(i * 16'h1111) ^ 16'h0F0F);
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'd0, 16'h0000, 4'(i), 4'(15 - i));
      step();
    end
    drive(1'b0, 4'd0, 16'h0000, 4'd6, 4'd0);
    chk("sweep_r6", src_data1, 16'h6666 ^ 16'h0F0F);
    chk("sweep_r0", src_data2, 16'h0000);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
